// File: rtl/nco_step_ramp.sv
// Slew-limited NCO step generator: a register write sets a target step, and the
// output either jumps to it or ramps toward it by at most `slew` every TICK_DIV cycles.
module nco_step_ramp #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      TICK_DIV   = 256,
  parameter logic [WIDTH-1:0] RESET_SLEW = WIDTH'(32'h0001_0000)
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_addr,
  input  logic [WIDTH-1:0] s_data,
  output logic [WIDTH-1:0] step_out,
  output logic             step_valid,
  output logic             settled
);

  localparam int unsigned      CntW       = $clog2(TICK_DIV);
  localparam logic [CntW-1:0]  TickMax    = CntW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] AddrTarget = '0;
  localparam logic [WIDTH-1:0] AddrSlew   = WIDTH'(1);

  typedef enum logic [0:0] {StIdle, StRamp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   tick_q, tick_d;
  logic [WIDTH-1:0]  step_q, step_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [WIDTH-1:0]  slew_q, slew_d;
  logic              step_valid_q, step_valid_d;

  logic              accept;
  logic [WIDTH:0]    sum_w;
  logic [WIDTH:0]    floor_w;
  logic [WIDTH-1:0]  ramp_next;

  assign s_ready    = (state_q == StIdle);
  assign settled    = (state_q == StIdle) && (step_q == target_q);
  assign step_out   = step_q;
  assign step_valid = step_valid_q;
  assign accept     = s_valid && s_ready;

  // One extra bit so neither the up-step nor the down-clamp comparison can wrap.
  assign sum_w   = {1'b0, step_q} + {1'b0, slew_q};
  assign floor_w = {1'b0, target_q} + {1'b0, slew_q};

  always_comb begin
    ramp_next = target_q;
    if (target_q > step_q) begin
      ramp_next = (sum_w > {1'b0, target_q}) ? target_q : sum_w[WIDTH-1:0];
    end else if (target_q < step_q) begin
      ramp_next = ({1'b0, step_q} < floor_w) ? target_q : step_q - slew_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    step_d       = step_q;
    target_d     = target_q;
    slew_d       = slew_q;
    step_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (s_addr == AddrTarget) begin
            target_d = s_data;
            if (s_data != step_q) begin
              if (slew_q == '0) begin
                step_d       = s_data;
                step_valid_d = 1'b1;
              end else begin
                tick_d  = '0;
                state_d = StRamp;
              end
            end
          end else if (s_addr == AddrSlew) begin
            slew_d = s_data;
          end
        end
      end
      StRamp: begin
        if (tick_q == TickMax) begin
          tick_d       = '0;
          step_d       = ramp_next;
          step_valid_d = 1'b1;
          if (ramp_next == target_q) begin
            state_d = StIdle;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      step_q       <= '0;
      target_q     <= '0;
      slew_q       <= RESET_SLEW;
      step_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      step_q       <= step_d;
      target_q     <= target_d;
      slew_q       <= slew_d;
      step_valid_q <= step_valid_d;
    end
  end

endmodule

// File: tb/tb_nco_step_ramp.sv
// Directed bench for nco_step_ramp with TICK_DIV=4: ramps, clamp, jump, stall,
// boundary writes and asynchronous reset mid-ramp.
module tb_nco_step_ramp;

  logic        aclk;
  logic        arst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_addr;
  logic [31:0] s_data;
  logic [31:0] step_out;
  logic        step_valid;
  logic        settled;

  int tests;
  int fails;

  nco_step_ramp #(
    .WIDTH     (32),
    .TICK_DIV  (4),
    .RESET_SLEW(32'h0001_0000)
  ) dut (
    .aclk      (aclk),
    .arst_n    (arst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_addr    (s_addr),
    .s_data    (s_data),
    .step_out  (step_out),
    .step_valid(step_valid),
    .settled   (settled)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  // Present a write and hold it until the edge that accepts it; returns 1ns after that edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    int n;
    s_valid = 1'b1;
    s_addr  = a;
    s_data  = d;
    n = 0;
    while (s_ready !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    chk("wr_ready", {31'b0, s_ready}, 32'd1);
    cyc();
    s_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_step;
    tests   = 0;
    fails   = 0;
    s_valid = 1'b0;
    s_addr  = '0;
    s_data  = '0;
    arst_n  = 1'b0;
    #3;
    chk("rst_step", step_out, 32'h0);
    chk("rst_valid", {31'b0, step_valid}, 32'd0);
    chk("rst_ready", {31'b0, s_ready}, 32'd1);
    chk("rst_settled", {31'b0, settled}, 32'd1);
    #9 arst_n = 1'b1;
    cyc();

    // Up-ramp 0 -> 0x300 at slew 0x100
    wr(32'd1, 32'h100);
    chk("slew_step", step_out, 32'h0);
    chk("slew_ready", {31'b0, s_ready}, 32'd1);
    wr(32'd0, 32'h300);
    chk("up_ready0", {31'b0, s_ready}, 32'd0);
    chk("up_settled0", {31'b0, settled}, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp_step = 32'(k / 4) * 32'h100;
      chk("up_step", step_out, exp_step);
      chk("up_valid", {31'b0, step_valid}, (k % 4 == 0) ? 32'd1 : 32'd0);
      chk("up_ready", {31'b0, s_ready}, (k == 12) ? 32'd1 : 32'd0);
      chk("up_settled", {31'b0, settled}, (k == 12) ? 32'd1 : 32'd0);
    end

    // Down-ramp with clamp at 0x50
    wr(32'd0, 32'h50);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp_step = (k < 4) ? 32'h300 : (k < 8) ? 32'h200 : (k < 12) ? 32'h100 : 32'h50;
      chk("dn_step", step_out, exp_step);
      chk("dn_valid", {31'b0, step_valid}, (k % 4 == 0) ? 32'd1 : 32'd0);
    end
    chk("dn_settled", {31'b0, settled}, 32'd1);

    // Target equal to current step: no pulse, stays idle
    wr(32'd0, 32'h50);
    chk("eq_valid", {31'b0, step_valid}, 32'd0);
    chk("eq_ready", {31'b0, s_ready}, 32'd1);
    cyc();
    chk("eq_valid2", {31'b0, step_valid}, 32'd0);
    chk("eq_step", step_out, 32'h50);

    // Unmapped address: consumed, no effect
    wr(32'd7, 32'h1234_5678);
    chk("a7_step", step_out, 32'h50);
    chk("a7_valid", {31'b0, step_valid}, 32'd0);
    chk("a7_settled", {31'b0, settled}, 32'd1);

    // Jump with slew 0
    wr(32'd1, 32'h0);
    wr(32'd0, 32'hDEAD_BEEF);
    chk("jmp_step", step_out, 32'hDEAD_BEEF);
    chk("jmp_valid", {31'b0, step_valid}, 32'd1);
    chk("jmp_ready", {31'b0, s_ready}, 32'd1);
    cyc();
    chk("jmp_valid2", {31'b0, step_valid}, 32'd0);
    chk("jmp_settled", {31'b0, settled}, 32'd1);

    // Top-of-range ramp: must clamp at 0xFFFF_FFFF without wrapping
    wr(32'd0, 32'hFFFF_FF00);
    chk("top_base", step_out, 32'hFFFF_FF00);
    wr(32'd1, 32'h100);
    wr(32'd0, 32'hFFFF_FFFF);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("top_step", step_out, (k == 4) ? 32'hFFFF_FFFF : 32'hFFFF_FF00);
    end
    chk("top_settled", {31'b0, settled}, 32'd1);

    // Stall: TARGET=0x10 held during a down-ramp to 0xFFFF_FD00
    wr(32'd0, 32'hFFFF_FD00);
    s_valid = 1'b1;
    s_addr  = 32'd0;
    s_data  = 32'h10;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp_step = (k < 4) ? 32'hFFFF_FFFF : (k < 8) ? 32'hFFFF_FEFF :
                 (k < 12) ? 32'hFFFF_FDFF : 32'hFFFF_FD00;
      chk("stl_step", step_out, exp_step);
      chk("stl_ready", {31'b0, s_ready}, (k == 12) ? 32'd1 : 32'd0);
    end
    cyc();
    s_valid = 1'b0;
    chk("stl_acc_ready", {31'b0, s_ready}, 32'd0);
    chk("stl_acc_step", step_out, 32'hFFFF_FD00);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("stl_ramp", step_out, (k == 4) ? 32'hFFFF_FC00 : 32'hFFFF_FD00);
    end

    // Asynchronous reset between ramp updates
    cyc();
    #3 arst_n = 1'b0;
    #1;
    chk("ar_step", step_out, 32'h0);
    chk("ar_settled", {31'b0, settled}, 32'd1);
    chk("ar_ready", {31'b0, s_ready}, 32'd1);
    chk("ar_valid", {31'b0, step_valid}, 32'd0);
    #22 arst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("ar_quiet", {31'b0, step_valid}, 32'd0);
      chk("ar_hold", step_out, 32'h0);
    end

    // Reset slew restored: ramp 0 -> 0x20000 takes two updates of 0x10000
    wr(32'd0, 32'h0002_0000);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("rs_step", step_out, 32'(k / 4) * 32'h0001_0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
